// File: rtl/ce_gen_bank_pkg.sv
// ce_gen_bank_pkg: channel config record, FSM states and default phase tables (12/6/3/1.5 MHz + video slices)
package ce_gen_bank_pkg;
  localparam int NCH_MAX = 16;
  localparam int CTR_MAX = 10;
  typedef struct packed {
    logic               on;
    logic [CTR_MAX-1:0] mask;
    logic [CTR_MAX-1:0] match;
  } chan_cfg_t;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  // ch0..3: 12/6/3/1.5 MHz from 24 MHz; ch4..7: four video slices of an 8-phase cycle
  localparam logic [47:0] RST_MASK_DEF  = {6'h07, 6'h07, 6'h07, 6'h07, 6'h0f, 6'h07, 6'h03, 6'h01};
  localparam logic [47:0] RST_MATCH_DEF = {6'h06, 6'h04, 6'h02, 6'h00, 6'h0f, 6'h07, 6'h03, 6'h01};
endpackage

// File: rtl/ce_gen_chan.sv
// ce_gen_chan: one channel's config (and shadow when CE_GEN_BANK_SHADOW_EN) plus registered phase compare
module ce_gen_chan
  import ce_gen_bank_pkg::*;
#(
  parameter int               CTR_W     = 6,
  parameter logic [CTR_W-1:0] RST_MASK  = '0,
  parameter logic [CTR_W-1:0] RST_MATCH = '0
) (
  input  logic             clk24,
  input  logic             reset,
  input  logic             we,
  input  logic             cfg_on,
  input  logic [CTR_W-1:0] cfg_mask,
  input  logic [CTR_W-1:0] cfg_match,
  input  logic             count,
`ifdef CE_GEN_BANK_SHADOW_EN
  input  logic             load,
`endif
  input  logic [CTR_W-1:0] ctr,
  output logic             ce
);
  localparam chan_cfg_t RST_CFG = '{on: 1'b1, mask: CTR_MAX'(RST_MASK), match: CTR_MAX'(RST_MATCH)};
  chan_cfg_t live, wcfg;
  assign wcfg = '{on: cfg_on, mask: CTR_MAX'(cfg_mask), match: CTR_MAX'(cfg_match)};
`ifdef CE_GEN_BANK_SHADOW_EN
  chan_cfg_t shadow;
  // a write landing on the load cycle goes straight through to live
  always_ff @(posedge clk24) begin
    if (reset) begin
      shadow <= RST_CFG;
      live   <= RST_CFG;
    end else begin
      if (we) shadow <= wcfg;
      if (load) live <= we ? wcfg : shadow;
    end
  end
`else
  always_ff @(posedge clk24) begin
    if (reset) live <= RST_CFG;
    else if (we) live <= wcfg;
  end
`endif
  always_ff @(posedge clk24) begin
    if (reset) ce <= 1'b0;
    else ce <= count && live.on && ((CTR_MAX'(ctr) & live.mask) == (live.match & live.mask));
  end
endmodule

// File: rtl/ce_gen_bank.sv
// ce_gen_bank: bank of phase-matched clock enables off a shared counter on clk24.
// Define CE_GEN_BANK_SHADOW_EN to double-buffer channel config, committing on wrap or resync.
module ce_gen_bank
  import ce_gen_bank_pkg::*;
#(
  parameter int                     NCH         = 8,
  parameter int                     CTR_W       = 6,
  parameter int                     INIT_CYCLES = 3,
  parameter logic [NCH*CTR_W-1:0]   RST_MASK    = (NCH*CTR_W)'(RST_MASK_DEF),
  parameter logic [NCH*CTR_W-1:0]   RST_MATCH   = (NCH*CTR_W)'(RST_MATCH_DEF)
) (
  input  logic             clk24,
  input  logic             reset,
  input  logic             hold,
  input  logic             resync,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [CTR_W-1:0] cfg_mask,
  input  logic [CTR_W-1:0] cfg_match,
  input  logic             cfg_on,
  output logic [NCH-1:0]   ce,
  output logic [CTR_W-1:0] ctr_q,
  output logic             wrap,
  output logic             ready
);
  localparam int SW = $clog2(INIT_CYCLES + 1) + 1;
  localparam logic [CTR_W-1:0] ONES = '1;
  state_t        st;
  logic [SW-1:0] settle;
  logic          count, wrap_gen;
  assign count    = (st == ST_RUN) && !hold && !resync;
  assign wrap_gen = count && (ctr_q == ONES);
  assign ready    = (st == ST_RUN);
  always_ff @(posedge clk24) begin
    if (reset) begin
      st     <= ST_INIT;
      settle <= '0;
      ctr_q  <= '0;
      wrap   <= 1'b0;
    end else if (st == ST_INIT) begin
      settle <= settle + 1'b1;
      if (settle == SW'(INIT_CYCLES - 1)) st <= ST_RUN;
    end else begin
      wrap  <= wrap_gen;
      ctr_q <= resync ? '0 : count ? ctr_q + 1'b1 : ctr_q;
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ce_gen_chan #(
      .CTR_W    (CTR_W),
      .RST_MASK (RST_MASK[g*CTR_W +: CTR_W]),
      .RST_MATCH(RST_MATCH[g*CTR_W +: CTR_W])
    ) u_ch (
      .clk24    (clk24),
      .reset    (reset),
      .we       (cfg_we && (cfg_addr == 4'(g))),
      .cfg_on   (cfg_on),
      .cfg_mask (cfg_mask),
      .cfg_match(cfg_match),
      .count    (count),
`ifdef CE_GEN_BANK_SHADOW_EN
      .load     (wrap_gen || ((st == ST_RUN) && resync)),
`endif
      .ctr      (ctr_q),
      .ce       (ce[g])
    );
  end
endmodule

// File: tb/tb_ce_gen_bank.sv
// tb_ce_gen_bank: randomized + directed stimulus against a behavioural phase/config model
module tb_ce_gen_bank;
  localparam int NCH = 8, CTR_W = 6, INIT_CYCLES = 3, PERIOD = 64;
  localparam int RMASK [8] = '{1, 3, 7, 15, 7, 7, 7, 7};
  localparam int RMATCH[8] = '{1, 3, 7, 15, 0, 2, 4, 6};
  logic clk24 = 0, reset = 1, hold = 0, resync = 0, cfg_we = 0, cfg_on = 0;
  logic [3:0] cfg_addr = 0;
  logic [CTR_W-1:0] cfg_mask = 0, cfg_match = 0;
  logic [NCH-1:0] ce;
  logic [CTR_W-1:0] ctr_q;
  logic wrap, ready;
  int nchk = 0, nerr = 0;
  int age, mctr;
  logic [NCH-1:0] mce;
  logic mwrap;
  bit mon[NCH], son[NCH];
  int mmask[NCH], mmatch[NCH], smask[NCH], smatch[NCH];

  always #5 clk24 = ~clk24;

  ce_gen_bank dut (
    .clk24(clk24), .reset(reset), .hold(hold), .resync(resync), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_match(cfg_match), .cfg_on(cfg_on),
    .ce(ce), .ctr_q(ctr_q), .wrap(wrap), .ready(ready)
  );

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // advance the model by one clock using the inputs currently driven, then compare after the edge
  task automatic cycle();
    bit run, cnt;
    int a;
    if (reset) begin
      age = 0; mctr = 0; mce = 0; mwrap = 0;
      for (int i = 0; i < NCH; i++) begin
        mon[i] = 1; son[i] = 1;
        mmask[i] = RMASK[i]; smask[i] = RMASK[i];
        mmatch[i] = RMATCH[i]; smatch[i] = RMATCH[i];
      end
    end else begin
      run = age >= INIT_CYCLES;
      cnt = run && !hold && !resync;
      for (int i = 0; i < NCH; i++)
        mce[i] = cnt && mon[i] && ((mctr & mmask[i]) == (mmatch[i] & mmask[i]));
      mwrap = cnt && (mctr == PERIOD - 1);
      a = int'(cfg_addr);
`ifdef CE_GEN_BANK_SHADOW_EN
      if (cfg_we && a < NCH) begin
        son[a] = cfg_on; smask[a] = int'(cfg_mask); smatch[a] = int'(cfg_match);
      end
      if (mwrap || (run && resync))
        for (int i = 0; i < NCH; i++) begin
          mon[i] = son[i]; mmask[i] = smask[i]; mmatch[i] = smatch[i];
        end
`else
      if (cfg_we && a < NCH) begin
        mon[a] = cfg_on; mmask[a] = int'(cfg_mask); mmatch[a] = int'(cfg_match);
      end
`endif
      if (run && resync) mctr = 0;
      else if (cnt) mctr = (mctr + 1) % PERIOD;
      if (!run) age++;
    end
    @(posedge clk24);
    #1;
    check("ready", int'(ready), int'(age >= INIT_CYCLES));
    check("ctr_q", int'(ctr_q), mctr);
    check("wrap", int'(wrap), int'(mwrap));
    check("ce", int'(ce), int'(mce));
  endtask

  task automatic run_to(input int v);
    for (int k = 0; k < 300 && mctr != v; k++) cycle();
    check("reach", int'(ctr_q), v);
  endtask

  task automatic wr(input int a, input int m, input int t, input bit on);
    cfg_we = 1; cfg_addr = 4'(a); cfg_mask = CTR_W'(m); cfg_match = CTR_W'(t); cfg_on = on;
    cycle();
    cfg_we = 0;
  endtask

  initial begin
    repeat (3) cycle();
    reset = 0;
    for (int k = 0; k < 6; k++) cycle();
    wr(0, 1, 1, 1);
    wr(1, 7, 6, 1);
    repeat (80) cycle();
    run_to(8'h1f);
    hold = 1;
    repeat (5) cycle();
    hold = 0;
    repeat (3) cycle();
    run_to(8'h3f);
    cycle();
    resync = 1; hold = 1;
    cycle();
    resync = 0; hold = 0;
    repeat (4) cycle();
    run_to(8'h10);
    wr(2, 3, 0, 1);
    repeat (70) cycle();
    wr(3, 0, 0, 1);
    repeat (10) cycle();
    run_to(8'h25);
    cfg_we = 1; cfg_addr = 4'(NCH); cfg_mask = '1; cfg_match = '1; cfg_on = 0; reset = 1;
    cycle();
    cfg_we = 0; reset = 0;
    repeat (12) cycle();
    for (int k = 0; k < 4000; k++) begin
      reset  = ($urandom_range(0, 299) == 0);
      hold   = ($urandom_range(0, 9) == 0);
      resync = ($urandom_range(0, 39) == 0);
      cfg_we = ($urandom_range(0, 4) == 0);
      cfg_addr = 4'($urandom_range(0, 15));
      cfg_mask = CTR_W'($urandom);
      cfg_match = CTR_W'($urandom);
      cfg_on = ($urandom_range(0, 3) != 0);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
